// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide, one bit per cycle, followed by a sign-fix cycle.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cancel,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [2*W-1:0]  acc_reg, acc_next;
    logic [W-1:0]    opd_reg, opd_next;
    logic            a_neg_reg, a_neg_next;
    logic            b_neg_reg, b_neg_next;
    logic            is_div_reg, is_div_next;
    logic            b_zero_reg, b_zero_next;
    logic [W-1:0]    hi_reg, hi_next;
    logic [W-1:0]    lo_reg, lo_next;
    logic            busy_reg, busy_next;

    logic            is_signed;
    logic [W-1:0]    a_mag, b_mag, addend;
    logic [W:0]      mul_sum, div_trial;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quo_fix, rem_fix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            opd_reg    <= '0;
            a_neg_reg  <= 1'b0;
            b_neg_reg  <= 1'b0;
            is_div_reg <= 1'b0;
            b_zero_reg <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            opd_reg    <= opd_next;
            a_neg_reg  <= a_neg_next;
            b_neg_reg  <= b_neg_next;
            is_div_reg <= is_div_next;
            b_zero_reg <= b_zero_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            busy_reg   <= busy_next;
        end
    end

    // Both multiply and divide keep the a-magnitude in the low half of the
    // accumulator (multiplier / dividend) and the b-magnitude in opd_reg.
    always_comb begin
        is_signed = ~op[0];
        a_mag     = (is_signed && a[W-1]) ? -a : a;
        b_mag     = (is_signed && b[W-1]) ? -b : b;
        addend    = acc_reg[0] ? opd_reg : {W{1'b0}};
        mul_sum   = {1'b0, acc_reg[2*W-1:W]} + {1'b0, addend};
        div_trial = acc_reg[2*W-1:W-1] - {1'b0, opd_reg};
        prod_fix  = (a_neg_reg ^ b_neg_reg) ? -acc_reg : acc_reg;
        quo_fix   = (a_neg_reg ^ b_neg_reg) ? -acc_reg[W-1:0] : acc_reg[W-1:0];
        // With a zero divisor the remainder ends up as |a|, so this restores raw a.
        rem_fix   = a_neg_reg ? -acc_reg[2*W-1:W] : acc_reg[2*W-1:W];

        state_next  = state_reg;
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        opd_next    = opd_reg;
        a_neg_next  = a_neg_reg;
        b_neg_next  = b_neg_reg;
        is_div_next = is_div_reg;
        b_zero_next = b_zero_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    case (op)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            a_neg_next  = is_signed & a[W-1];
                            b_neg_next  = is_signed & b[W-1];
                            is_div_next = op[1];
                            b_zero_next = (b == '0);
                            acc_next    = {{W{1'b0}}, a_mag};
                            opd_next    = b_mag;
                            cnt_next    = '0;
                            state_next  = CALC;
                        end
                        3'b100:  hi_next = a;
                        3'b101:  lo_next = a;
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (cancel) begin
                    state_next = IDLE;
                end else begin
                    if (!is_div_reg)
                        acc_next = {mul_sum, acc_reg[W-1:1]};
                    else if (!div_trial[W])
                        acc_next = {div_trial[W-1:0], acc_reg[W-2:0], 1'b1};
                    else
                        acc_next = {acc_reg[2*W-2:0], 1'b0};
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == CW'(W - 1))
                        state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
                if (!cancel) begin
                    if (is_div_reg) begin
                        hi_next = rem_fix;
                        lo_next = b_zero_reg ? {W{1'b1}} : quo_fix;
                    end else begin
                        hi_next = prod_fix[2*W-1:W];
                        lo_next = prod_fix[W-1:0];
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

    assign busy = busy_reg;
    assign done = (state_reg == FIX) && !cancel;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO pushed at issue, popped on done.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b111;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cancel = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;
    res_t sbq[$];

    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference results from plain SystemVerilog arithmetic.
    function automatic res_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        res_t r;
        longint          sp;
        longint unsigned up;
        int              q, rm;
        case (o)
            3'b000: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                r.hi = sp[63:32]; r.lo = sp[31:0];
            end
            3'b001: begin
                up = {32'h0, x} * {32'h0, y};
                r.hi = up[63:32]; r.lo = up[31:0];
            end
            3'b010: begin
                if (y == 0) begin
                    r.hi = x; r.lo = '1;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    r.hi = '0; r.lo = 32'h8000_0000;
                end else begin
                    q = $signed(x) / $signed(y);
                    rm = $signed(x) % $signed(y);
                    r.hi = rm; r.lo = q;
                end
            end
            default: begin
                if (y == 0) begin
                    r.hi = x; r.lo = '1;
                end else begin
                    r.hi = x % y; r.lo = x / y;
                end
            end
        endcase
        return r;
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el);
        int   bc = 0;
        int   dc = 0;
        res_t e;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        sbq.push_back('{hi: eh, lo: el});
        @(negedge clk);
        start = 1'b0;
        while (busy && bc < 200) begin
            if (done) begin
                dc++;
                e = sbq.pop_front();
            end
            bc++;
            @(negedge clk);
        end
        if (dc == 0 && sbq.size() > 0) e = sbq.pop_front();
        chk("busy_cycles", 64'(bc), 64'd33);
        chk("done_pulses", 64'(dc), 64'd1);
        chk("hi", {32'h0, hi}, {32'h0, e.hi});
        chk("lo", {32'h0, lo}, {32'h0, e.lo});
        hi_m = e.hi; lo_m = e.lo;
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h (exp %h %h)", o, x, y, hi, lo, e.hi, e.lo);
    endtask

    initial begin
        int          dc;
        logic [31:0] ra, rb;
        res_t        r;

        #12;
        chk("rst_busy", {63'h0, busy}, 64'd0);
        chk("rst_done", {63'h0, done}, 64'd0);
        chk("rst_hi", {32'h0, hi}, 64'd0);
        chk("rst_lo", {32'h0, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(3'b000, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        do_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        do_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op(3'b011, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);
        do_op(3'b011, 32'h0000_0064, 32'h0, 32'h0000_0064, 32'hFFFF_FFFF);
        do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        do_op(3'b010, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 0) rb = rb >> 20;
            if (rb == 0) rb = 32'd13;
            r = model(3'(i % 4), ra, rb);
            do_op(3'(i % 4), ra, rb, r.hi, r.lo);
        end

        // MTHI: visible one edge later, never busy.
        @(negedge clk);
        op = 3'b100; a = 32'h1234_5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mthi_hi", {32'h0, hi}, 64'h1234_5678);
        chk("mthi_busy", {63'h0, busy}, 64'd0);
        chk("mthi_lo_kept", {32'h0, lo}, {32'h0, lo_m});
        hi_m = 32'h1234_5678;
        $display("mthi a=12345678 -> hi=%h busy=%b", hi, busy);

        // MULT cancelled mid-CALC; an MTLO pulsed while busy must be ignored.
        @(negedge clk);
        op = 3'b000; a = 32'd5; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dc = 0;
        repeat (4) begin
            if (done) dc++;
            @(negedge clk);
        end
        op = 3'b101; a = 32'hDEAD_BEEF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            if (done) dc++;
            @(negedge clk);
        end
        chk("busy_before_cancel", {63'h0, busy}, 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", {63'h0, busy}, 64'd0);
        repeat (40) begin
            if (done) dc++;
            @(negedge clk);
        end
        chk("cancel_done", 64'(dc), 64'd0);
        chk("cancel_hi", {32'h0, hi}, {32'h0, hi_m});
        chk("cancel_lo", {32'h0, lo}, {32'h0, lo_m});
        $display("cancelled mult -> hi=%h lo=%h busy=%b", hi, lo, busy);

        // cancel in IDLE does not block an MTLO.
        op = 3'b101; a = 32'hCAFE_0001; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("idle_cancel_mtlo", {32'h0, lo}, 64'hCAFE_0001);
        lo_m = 32'hCAFE_0001;
        $display("mtlo with cancel -> lo=%h", lo);

        // Async reset mid-DIV.
        op = 3'b010; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'h0, busy}, 64'd0);
        chk("arst_done", {63'h0, done}, 64'd0);
        chk("arst_hi", {32'h0, hi}, 64'd0);
        chk("arst_lo", {32'h0, lo}, 64'd0);
        $display("async reset mid-div -> busy=%b hi=%h lo=%h", busy, hi, lo);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(3'b001, 32'd6, 32'd7, 32'h0, 32'h0000_002A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with HI/LO result registers for the dmips datapath. It sits directly downstream of `regfile` and consumes the two read-port values (`rd1` as rs, `rd2` as rt) for MULT/MULTU/DIV/DIVU/MTHI/MTLO. It computes over DATA_WIDTH cycles, holds the result in HI/LO for MFHI/MFLO, and raises `busy` so the pipeline controller can stall dependent instructions.

## Interface
- DATA_WIDTH, 32, operand, HI and LO width; must be even and ≥ 4
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  operation request; sampled only while `busy`=0
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
- a  in  DATA_WIDTH  rs operand (from regfile `rd1`)
- b  in  DATA_WIDTH  rt operand (from regfile `rd2`)
- cancel  in  1  abort the in-flight operation (exception flush)
- busy  out  1  multi-cycle operation in progress
- done  out  1  one-cycle pulse when HI/LO are written by MULT/DIV
- hi  out  DATA_WIDTH  HI register
- lo  out  DATA_WIDTH  LO register

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1, op ∈ {MULT, MULTU, DIV, DIVU}: latch operands, converting to magnitudes for signed ops; record the result signs; counter=0; go to CALC.
- IDLE, start=1, op=MTHI: hi←a. op=MTLO: lo←a. Takes one edge; stay in IDLE; busy stays 0 and done stays 0.
- IDLE, start=1, op=11x: no effect.
- CALC: one iteration per cycle for DATA_WIDTH cycles, then go to FIX.
  - Multiply: shift-add, one multiplier bit per cycle, 2·DATA_WIDTH-bit accumulator.
  - Divide: restoring, one quotient bit per cycle.
- FIX: apply sign correction; write hi/lo; done=1 for this cycle; go to IDLE.
- Multiply result: {hi, lo} = full 2·DATA_WIDTH-bit product. For MULT, the product is negated when the operand signs differ.
- Divide result: lo = quotient, hi = remainder.
  - DIV: quotient is negative iff the operand signs differ; remainder takes the sign of the dividend (truncation toward zero).
  - Most-negative ÷ −1: lo = most-negative value, hi = 0.
- Divide by zero (b=0): lo = all ones, hi = a. This applies to both DIV and DIVU, with a taken as the raw dividend. The operation still takes full latency.
- Outside FIX and MTHI/MTLO writes, hi and lo hold their values.
- start while busy=1: ignored. It is not queued.
- cancel=1 in CALC or FIX: go to IDLE at the next edge. hi/lo are unchanged and done is not asserted. cancel takes priority over FIX's write. cancel in IDLE has no effect and does not block a simultaneous start.
- rst_n low (any time, including mid-operation): state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, immediately and without waiting for a clock edge.

## Timing
- Edge E0: start accepted.
- busy=1 from after E0 through the FIX cycle. busy = (state ≠ IDLE), registered.
- CALC occupies the DATA_WIDTH edges E1..E32 (for DATA_WIDTH=32).
- FIX is the cycle after E32. hi/lo are written at edge E33. done is asserted during the FIX cycle, combinationally decoded from state.
- Total latency: DATA_WIDTH+1 edges from acceptance to HI/LO valid. With the default width, HI/LO are valid after E33.
- busy deasserts with the FIX→IDLE transition at E33. A new start is accepted on the first edge after that.
- MTHI/MTLO: value visible on hi/lo one edge after acceptance.
- hi/lo are registered outputs and never glitch mid-cycle.

## Test plan
- Reset, then MULT a=0xFFFFFFFD (−3), b=0x00000005 → after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFF1; done high for exactly one cycle; busy high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then MULT with the same operands → hi=0x00000000, lo=0x00000001.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=0x0000000E, hi=0x00000002.
- DIVU a=0x00000064, b=0 → lo=0xFFFFFFFF, hi=0x00000064. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI a=0x12345678 → hi=0x12345678 next edge with busy=0. Then start MULT and assert cancel at CALC cycle 10 → busy=0 next edge, hi remains 0x12345678, no done. A start pulsed while busy is ignored, with hi/lo unaffected.
- Assert rst_n low mid-DIV (cycle 20), asynchronously between edges → busy, done, hi and lo drop to 0 before the next edge. Release reset; a fresh MULTU 6×7 gives lo=0x0000002A, hi=0.
